calc_bank: RTL and testbench

// - Parametrised successor to the single-accumulator calculator: a bank of NUM_ACC accumulators, DATA_W wide.
// - Buttons are synchronised and edge-detected; btnl/btnr step the op select; btnc executes; btnu clears; btnd undoes.
// - 2-state execute FSM, signed overflow flag, one-level undo. Sits between board buttons/switches and LEDs.

---
 rtl/calc_bank.sv | 220 ++++++++++++++++++++++
 tb/tb_calc_bank.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_bank.sv
// calc_bank: bank of NUM_ACC accumulators driven by board buttons.
// Optional debounce stage enabled by defining CALC_DEBOUNCE_EN.
module calc_bank #(
    parameter int DATA_W    = 16,
    parameter int NUM_ACC   = 4,
    parameter int DB_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       btnc,
    input  logic                       btnl,
    input  logic                       btnr,
    input  logic                       btnu,
    input  logic                       btnd,
    input  logic [DATA_W-1:0]          sw,
    input  logic [$clog2(NUM_ACC)-1:0] acc_sel,
    output logic [DATA_W-1:0]          led,
    output logic [2:0]                 op_sel,
    output logic                       busy,
    output logic                       ovf
);

    localparam int SEL_W = $clog2(NUM_ACC);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int M     = DATA_W - 1;

    typedef enum logic {S_IDLE, S_EXEC} state_t;
    typedef enum logic [1:0] {A_EXE, A_CLR, A_UNDO} act_t;

    // bit order: 0 c, 1 l, 2 r, 3 u, 4 d
    logic [4:0] btn_w, s1_q, s2_q, lvl_w, prev_q, pls_q;
    assign btn_w = {btnd, btnu, btnr, btnl, btnc};

    // two-flop synchroniser for all buttons
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= btn_w;
            s2_q <= s1_q;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q [5];
    logic [4:0]       db_q;

    // level changes only after DB_CYCLES consecutive cycles at the new value
    always_ff @(posedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (rst) begin
                cnt_q[i] <= '0;
                db_q[i]  <= 1'b0;
            end else if (s2_q[i] == db_q[i]) begin
                cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
                cnt_q[i] <= '0;
                db_q[i]  <= s2_q[i];
            end else begin
                cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end
    assign lvl_w = db_q;
`else
    // DB_CYCLES has no effect without the debounce stage
    logic unused_db;
    assign unused_db = ^DB_CYCLES;
    assign lvl_w = s2_q;
`endif

    // registered rising-edge pulse, one cycle per press
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= '0;
            pls_q  <= '0;
        end else begin
            prev_q <= lvl_w;
            pls_q  <= lvl_w & ~prev_q;
        end
    end

    logic p_c, p_l, p_r, p_u, p_d, p_act;
    assign p_c   = pls_q[0];
    assign p_l   = pls_q[1];
    assign p_r   = pls_q[2];
    assign p_u   = pls_q[3];
    assign p_d   = pls_q[4];
    assign p_act = p_u | p_c | p_d;

    state_t            state_q, state_d;
    act_t              act_q, act_w;
    logic [SEL_W-1:0]  idx_q, uidx_q;
    logic [DATA_W-1:0] opnd_q, uval_q;
    logic [2:0]        cop_q, opsel_q, opsel_d;
    logic              uvld_q, ovf_q, start_w;
    logic [DATA_W-1:0] acc_q [NUM_ACC];
    logic [DATA_W-1:0] led_q;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // next state, action priority and op select stepping
    always_comb begin
        state_d = state_q;
        start_w = 1'b0;
        act_w   = A_EXE;
        opsel_d = opsel_q;
        unique case (state_q)
            S_IDLE: begin
                if (p_act) begin
                    start_w = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (p_u)      act_w = A_CLR;
        else if (p_c) act_w = A_EXE;
        else if (p_d) act_w = A_UNDO;
        if (!p_act && (p_l ^ p_r)) begin
            opsel_d = p_l ? opsel_q + 3'd1 : opsel_q - 3'd1;
        end
    end

    logic [DATA_W-1:0] a_w, b_w, sum_w, dif_w, res_w;
    logic [SH_W-1:0]   sh_w;
    logic              ovf_w;
    assign a_w   = acc_q[idx_q];
    assign b_w   = opnd_q;
    assign sh_w  = opnd_q[SH_W-1:0];
    assign sum_w = a_w + b_w;
    assign dif_w = a_w - b_w;

    // ALU on the captured operands
    always_comb begin
        res_w = '0;
        ovf_w = 1'b0;
        unique case (cop_q)
            3'd0: res_w = a_w & b_w;
            3'd1: res_w = a_w | b_w;
            3'd2: begin
                res_w = sum_w;
                ovf_w = (a_w[M] == b_w[M]) && (sum_w[M] != a_w[M]);
            end
            3'd3: begin
                res_w = dif_w;
                ovf_w = (a_w[M] != b_w[M]) && (dif_w[M] != a_w[M]);
            end
            3'd4: res_w = a_w ^ b_w;
            3'd5: res_w = a_w << sh_w;
            3'd6: res_w = a_w >> sh_w;
            3'd7: res_w = $signed(a_w) >>> sh_w;
            default: res_w = '0;
        endcase
    end

    // capture, accumulator write-back, undo record and led
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
            act_q   <= A_EXE;
            idx_q   <= '0;
            opnd_q  <= '0;
            cop_q   <= '0;
            opsel_q <= 3'd2;
            uidx_q  <= '0;
            uval_q  <= '0;
            uvld_q  <= 1'b0;
            ovf_q   <= 1'b0;
            led_q   <= '0;
        end else begin
            opsel_q <= opsel_d;
            led_q   <= acc_q[acc_sel];
            if (start_w) begin
                act_q  <= act_w;
                idx_q  <= acc_sel;
                opnd_q <= sw;
                cop_q  <= opsel_q;
            end
            if (state_q == S_EXEC) begin
                case (act_q)
                    A_EXE: begin
                        acc_q[idx_q] <= res_w;
                        uidx_q       <= idx_q;
                        uval_q       <= a_w;
                        uvld_q       <= 1'b1;
                        ovf_q        <= ovf_w;
                    end
                    A_CLR: begin
                        acc_q[idx_q] <= '0;
                        uidx_q       <= idx_q;
                        uval_q       <= a_w;
                        uvld_q       <= 1'b1;
                        ovf_q        <= 1'b0;
                    end
                    A_UNDO: begin
                        if (uvld_q) begin
                            acc_q[uidx_q] <= uval_q;
                            uvld_q        <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led    = led_q;
    assign op_sel = opsel_q;
    assign busy   = (state_q == S_EXEC);
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_calc_bank.sv
// tb_calc_bank: table vectors plus scoreboard checks for calc_bank.
// Define CALC_DEBOUNCE_EN to exercise the debounce build (DB_CYCLES=4).
module tb_calc_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        btnc = 0, btnl = 0, btnr = 0, btnu = 0, btnd = 0;
    logic [15:0] sw = '0;
    logic [1:0]  acc_sel = '0;
    logic [15:0] led;
    logic [2:0]  op_sel;
    logic        busy, ovf;

    calc_bank #(.DATA_W(16), .NUM_ACC(4), .DB_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .btnc(btnc), .btnl(btnl), .btnr(btnr),
        .btnu(btnu), .btnd(btnd),
        .sw(sw), .acc_sel(acc_sel),
        .led(led), .op_sel(op_sel),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk = ~clk;

`ifdef CALC_DEBOUNCE_EN
    localparam int HOLD = 6;
`else
    localparam int HOLD = 3;
`endif
    localparam int SETTLE = 16;

    localparam logic [4:0] M_C = 5'b00001;
    localparam logic [4:0] M_L = 5'b00010;
    localparam logic [4:0] M_R = 5'b00100;
    localparam logic [4:0] M_U = 5'b01000;
    localparam logic [4:0] M_D = 5'b10000;

    typedef struct {
        string       nm;
        logic [15:0] led;
        logic        ovf;
        bit          use_ovf;
    } sb_t;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] sw;
        logic [15:0] exp;
        logic        ovf;
    } vec_t;

    sb_t  sb[$];
    vec_t tbl[12];
    int   n_vec = 0;
    int   n_bad = 0;
    int   busy_cyc = 0;
    int   b0;
    logic [2:0] mdl_op = 3'd2;

    always @(posedge clk) if (busy === 1'b1) busy_cyc++;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] m);
        {btnd, btnu, btnr, btnl, btnc} = m;
    endtask

    task automatic press(input logic [4:0] m);
        @(negedge clk);
        drive(m);
        repeat (HOLD) @(negedge clk);
        drive(5'b0);
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic sb_check();
        sb_t e;
        if (sb.size() == 0) begin
            chk("scoreboard empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({e.nm, " led"}, 32'(led), 32'(e.led));
            if (e.use_ovf) chk({e.nm, " ovf"}, 32'(ovf), 32'(e.ovf));
        end
    endtask

    task automatic act(input logic [4:0] m, input logic [1:0] sel,
                       input logic [15:0] swv, input string nm,
                       input logic [15:0] e_led, input logic e_ovf);
        acc_sel = sel;
        sw = swv;
        sb.push_back('{nm, e_led, e_ovf, 1'b1});
        press(m);
        sb_check();
    endtask

    task automatic peek(input logic [1:0] idx, input logic [15:0] exp, input string nm);
        @(negedge clk);
        acc_sel = idx;
        sb.push_back('{nm, exp, 1'b0, 1'b0});
        repeat (3) @(negedge clk);
        sb_check();
    endtask

    task automatic set_op(input logic [2:0] target);
        for (int i = 0; i < 8 && mdl_op != target; i++) begin
            press(M_L);
            mdl_op = mdl_op + 3'd1;
        end
        chk($sformatf("set_op %0d", target), 32'(op_sel), 32'(target));
    endtask

    initial begin
        tbl[0]  = '{3'd2, 16'h1234, 16'h1234, 1'b0};
        tbl[1]  = '{3'd1, 16'h00F0, 16'h12F4, 1'b0};
        tbl[2]  = '{3'd0, 16'h0FF0, 16'h02F0, 1'b0};
        tbl[3]  = '{3'd4, 16'hFFFF, 16'hFD0F, 1'b0};
        tbl[4]  = '{3'd7, 16'h0004, 16'hFFD0, 1'b0};
        tbl[5]  = '{3'd6, 16'h0011, 16'h7FE8, 1'b0};
        tbl[6]  = '{3'd5, 16'hFFF3, 16'hFF40, 1'b0};
        tbl[7]  = '{3'd3, 16'h7FFF, 16'h7F41, 1'b1};
        tbl[8]  = '{3'd2, 16'h0001, 16'h7F42, 1'b0};
        tbl[9]  = '{3'd3, 16'h8000, 16'hFF42, 1'b1};
        tbl[10] = '{3'd2, 16'h8000, 16'h7F42, 1'b1};
        tbl[11] = '{3'd3, 16'h0002, 16'h7F40, 1'b0};

        // reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst led", 32'(led), 32'h0);
        chk("rst op_sel", 32'(op_sel), 32'd2);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        for (int i = 0; i < 4; i++) peek(2'(i), 16'h0, $sformatf("rst acc%0d", i));

        // overflow into acc[1] and exact latency
        act(M_C, 2'd1, 16'h7FFF, "acc1 first", 16'h7FFF, 1'b0);
`ifndef CALC_DEBOUNCE_EN
        acc_sel = 2'd1;
        sw = 16'h0001;
        @(negedge clk);
        btnc = 1'b1;
        @(posedge clk);
        repeat (2) @(posedge clk);
        #1 chk("lat busy k+2", 32'(busy), 32'd0);
        @(posedge clk);
        #1 chk("lat busy k+3", 32'(busy), 32'd1);
        @(posedge clk);
        #1 chk("lat busy k+4", 32'(busy), 32'd0);
        chk("lat led k+4", 32'(led), 32'h7FFF);
        chk("lat ovf k+4", 32'(ovf), 32'd1);
        @(posedge clk);
        #1 chk("lat led k+5", 32'(led), 32'h8000);
        @(negedge clk);
        btnc = 1'b0;
        repeat (SETTLE) @(negedge clk);
`else
        act(M_C, 2'd1, 16'h0001, "acc1 ovf", 16'h8000, 1'b1);
`endif
        act(M_D, 2'd1, 16'h0000, "undo keeps ovf", 16'h7FFF, 1'b1);

        // op table on acc[3]
        for (int i = 0; i < 12; i++) begin
            set_op(tbl[i].op);
            act(M_C, 2'd3, tbl[i].sw, $sformatf("vec%0d", i), tbl[i].exp, tbl[i].ovf);
        end

        // op_sel wrap with a held button
        set_op(3'd7);
        @(negedge clk);
        btnl = 1'b1;
        repeat (20) @(negedge clk);
        btnl = 1'b0;
        repeat (SETTLE) @(negedge clk);
        mdl_op = 3'd0;
        chk("held btnl wrap", 32'(op_sel), 32'd0);
        press(M_R);
        mdl_op = 3'd7;
        chk("btnr wrap", 32'(op_sel), 32'd7);
        press(M_L | M_R);
        chk("btnl+btnr", 32'(op_sel), 32'd7);
        set_op(3'd2);

        // clear and undo
        act(M_C, 2'd2, 16'h0042, "acc2 set", 16'h0042, 1'b0);
        act(M_C, 2'd0, 16'h0005, "acc0 set", 16'h0005, 1'b0);
        act(M_U, 2'd0, 16'h0000, "clr acc0", 16'h0000, 1'b0);
        act(M_D, 2'd2, 16'h0000, "undo acc2 kept", 16'h0042, 1'b0);
        peek(2'd0, 16'h0005, "undo acc0");
        act(M_D, 2'd2, 16'h0000, "undo2 acc2", 16'h0042, 1'b0);
        peek(2'd0, 16'h0005, "undo2 acc0");

        // btnc pulse arriving while busy with a clear
        acc_sel = 2'd3;
        sw = 16'h0011;
        b0 = busy_cyc;
        sb.push_back('{"drop", 16'h0000, 1'b0, 1'b1});
        @(negedge clk);
        btnu = 1'b1;
        @(negedge clk);
        btnc = 1'b1;
        repeat (HOLD) @(negedge clk);
        drive(5'b0);
        repeat (SETTLE) @(negedge clk);
        sb_check();
        chk("drop busy cycles", 32'(busy_cyc - b0), 32'd1);
        act(M_D, 2'd3, 16'h0000, "undo after drop", 16'h7F40, 1'b0);

        // clear and execute in the same cycle
        act(M_C, 2'd3, 16'h0011, "acc3 add", 16'h7F51, 1'b0);
        b0 = busy_cyc;
        act(M_U | M_C | M_L, 2'd3, 16'h0011, "u+c same", 16'h0000, 1'b0);
        chk("u+c busy cycles", 32'(busy_cyc - b0), 32'd1);
        chk("u+c op_sel", 32'(op_sel), 32'd2);

`ifdef CALC_DEBOUNCE_EN
        // glitch shorter than DB_CYCLES, then a valid press
        b0 = busy_cyc;
        @(negedge clk);
        btnc = 1'b1;
        repeat (3) @(negedge clk);
        btnc = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("glitch busy", 32'(busy_cyc - b0), 32'd0);
        peek(2'd3, 16'h0000, "glitch acc3");
        b0 = busy_cyc;
        @(negedge clk);
        btnc = 1'b1;
        repeat (4) @(negedge clk);
        btnc = 1'b0;
        repeat (SETTLE) @(negedge clk);
        chk("db4 busy", 32'(busy_cyc - b0), 32'd1);
        peek(2'd3, 16'h0011, "db4 acc3");
`endif

        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
